// File: rtl/rotr_pkg.sv
// Shared types and helpers for the iterative rotate-right unit.
// Optional build macro used by rotr_iter: ROTR_ZERO_FASTPATH_EN.
package rotr_pkg;

    // Widest operand the rotate helper can carry.
    localparam int ROTR_MAX_W = 1024;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    // Number of barrel stages, one per shift-amount bit.
    function automatic int rotr_shift_w(input int w);
        return $clog2(w);
    endfunction

    // Rotate the low w bits of data right by k (k taken mod w).
    // Bits above w must be zero on entry and are zero on exit.
    function automatic logic [ROTR_MAX_W-1:0] rotr_by(
        input logic [ROTR_MAX_W-1:0] data,
        input int unsigned           k,
        input int unsigned           w
    );
        logic [ROTR_MAX_W-1:0] mask;
        int unsigned           s;
        s    = k & (w - 1);
        mask = (ROTR_MAX_W'(1) << w) - ROTR_MAX_W'(1);
        return ((data >> s) | (data << (w - s))) & mask;
    endfunction

endpackage

// File: rtl/rotr_iter_step.sv
// One conditional barrel stage: rotate right by 2**stage when en is set.
// Shared by all stages; the caller walks stage from 0 upward.
module rotr_iter_step
    import rotr_pkg::*;
#(
    parameter int DATA_WIDTH = 256,
    parameter int STG_W      = 4
) (
    input  logic [DATA_WIDTH-1:0] d,
    input  logic [STG_W-1:0]      stage,
    input  logic                  en,
    output logic [DATA_WIDTH-1:0] q
);

    logic [ROTR_MAX_W-1:0] wide;
    logic [ROTR_MAX_W-1:0] rot;

    assign wide = ROTR_MAX_W'(d);
    assign rot  = rotr_by(wide, 32'd1 << stage, DATA_WIDTH);
    assign q    = en ? DATA_WIDTH'(rot) : d;

endmodule

// File: rtl/rotr_iter.sv
// Multi-cycle rotate-right unit, one barrel stage per cycle.
// Build macro: ROTR_ZERO_FASTPATH_EN (zero amount skips the stages).
module rotr_iter
    import rotr_pkg::*;
#(
    parameter int DATA_WIDTH = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] a_in,
    input  logic [DATA_WIDTH-1:0] shift_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] a_out,
    output logic                  busy
);

    localparam int SHIFT_W = rotr_shift_w(DATA_WIDTH);
    localparam int STG_W   = $clog2(SHIFT_W + 1);

    state_t                state;
    state_t                state_n;
    logic [DATA_WIDTH-1:0] data;
    logic [DATA_WIDTH-1:0] step_q;
    logic [SHIFT_W-1:0]    amt;
    logic [STG_W-1:0]      stage;
    logic                  last;
    logic                  accept;
    logic                  zero_amt;
    logic                  unused_shift_hi;

    assign in_ready  = enable && (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign accept    = in_valid && in_ready;
    assign last      = (stage == STG_W'(SHIFT_W - 1));

    assign unused_shift_hi = ^shift_in[DATA_WIDTH-1:SHIFT_W];

`ifdef ROTR_ZERO_FASTPATH_EN
    assign zero_amt = (shift_in[SHIFT_W-1:0] == '0);
`else
    assign zero_amt = 1'b0;
`endif

    // amt is shifted down each stage, so bit 0 gates the current stage.
    rotr_iter_step #(
        .DATA_WIDTH (DATA_WIDTH),
        .STG_W      (STG_W)
    ) u_step (
        .d     (data),
        .stage (stage),
        .en    (amt[0]),
        .q     (step_q)
    );

    // Next-state decode for IDLE -> SHIFT -> DONE -> IDLE.
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_n = zero_amt ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (enable && last) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                if (enable && out_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State register; enable low freezes the FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else if (enable) begin
            state <= state_n;
        end
    end

    // Operand capture, per-stage rotate and result latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data  <= '0;
            amt   <= '0;
            stage <= '0;
            a_out <= '0;
        end else if (enable) begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        data  <= a_in;
                        amt   <= shift_in[SHIFT_W-1:0];
                        stage <= '0;
                        if (zero_amt) begin
                            a_out <= a_in;
                        end
                    end
                end
                SHIFT: begin
                    data  <= step_q;
                    amt   <= amt >> 1;
                    stage <= stage + STG_W'(1);
                    if (last) begin
                        a_out <= step_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rotr_iter.sv
// Self-checking bench for rotr_iter: vector table, corner sequences
// and random ops, all results checked through a scoreboard queue.
module tb_rotr_iter;

    typedef struct {
        logic [255:0] a;
        logic [255:0] sh;
        logic [255:0] ex;
        int           lat;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         enable;
    logic         in_valid;
    logic         in_ready;
    logic [255:0] a_in;
    logic [255:0] shift_in;
    logic         out_valid;
    logic         out_ready;
    logic [255:0] a_out;
    logic         busy;

    int           checks = 0;
    int           errors = 0;
    int           zlat;
    logic [255:0] exp_q[$];

    always #5 clk = ~clk;

    rotr_iter #(
        .DATA_WIDTH (256)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_in      (a_in),
        .shift_in  (shift_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .a_out     (a_out),
        .busy      (busy)
    );

    function automatic logic [255:0] ref_rotr(
        input logic [255:0] a,
        input logic [255:0] sh
    );
        logic [255:0] r;
        logic [7:0]   k;
        k = sh[7:0];
        for (int i = 0; i < 256; i++) begin
            r[8'(i)] = a[8'(i) + k];
        end
        return r;
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int w = 0; w < 8; w++) begin
            v[w*32 +: 32] = $urandom;
        end
        return v;
    endfunction

    task automatic chk(
        input string        name,
        input logic [255:0] act,
        input logic [255:0] ex
    );
        checks++;
        if (act !== ex) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, ex);
        end
    endtask

    // Offer an operand and push its expected result at the accept edge.
    task automatic accept(
        input logic [255:0] a,
        input logic [255:0] sh,
        input logic [255:0] ex
    );
        int n;
        n        = 0;
        a_in     = a;
        shift_in = sh;
        in_valid = 1'b1;
        while (!in_ready && n < 64) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("in_ready_before_accept", 256'(in_ready), 256'd1);
        @(posedge clk);
        exp_q.push_back(ex);
        #1;
        in_valid = 1'b0;
    endtask

    // Wait for out_valid (lat counts edges after accept), compare, consume.
    task automatic collect(
        input int lat0,
        input int exp_lat,
        input bit take
    );
        int           lat;
        logic [255:0] e;
        lat = lat0;
        while (!out_valid && lat < lat0 + 64) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("latency", 256'(lat), 256'(exp_lat));
        if (exp_q.size() == 0) begin
            chk("scoreboard_nonempty", 256'(exp_q.size()), 256'd1);
            e = '0;
        end else begin
            e = exp_q.pop_front();
        end
        chk("a_out", a_out, e);
        if (take) begin
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
            chk("out_valid_after_take", 256'(out_valid), 256'd0);
            chk("a_out_kept_after_take", a_out, e);
        end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t         tbl[9];
        logic [255:0] pat;
        logic [255:0] a1;
        logic [255:0] a2;
        logic [255:0] e1;
        logic [255:0] sh;
        int           el;

`ifdef ROTR_ZERO_FASTPATH_EN
        zlat = 0;
`else
        zlat = 8;
`endif
        pat = 256'h0123456789ABCDEF_FEDCBA9876543210_DEADBEEFCAFEF00D_A5A55A5A12345678;

        tbl[0] = '{256'h1, 256'd1, 256'h1 << 255, 8};
        tbl[1] = '{256'hFFFF, 256'd17, 256'hFFFF << 239, 8};
        tbl[2] = '{256'hFFFF, 256'd273, 256'hFFFF << 239, 8};
        tbl[3] = '{pat, 256'd0, pat, zlat};
        tbl[4] = '{pat, 256'd256, pat, zlat};
        tbl[5] = '{256'h1, 256'd255, 256'h2, 8};
        tbl[6] = '{256'h1 << 255, 256'd128, 256'h1 << 127, 8};
        tbl[7] = '{256'hF0, 256'd4, 256'hF, 8};
        tbl[8] = '{256'h3, 256'd1, (256'h1 << 255) | 256'h1, 8};

        rst_n     = 1'b0;
        enable    = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a_in      = '0;
        shift_in  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_a_out", a_out, 256'd0);
        chk("reset_out_valid", 256'(out_valid), 256'd0);
        chk("reset_busy", 256'(busy), 256'd0);
        chk("reset_in_ready", 256'(in_ready), 256'd1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 9; i++) begin
            accept(tbl[i].a, tbl[i].sh, tbl[i].ex);
            collect(0, tbl[i].lat, 1'b1);
        end

        // Result held in DONE while a new operand is waiting.
        a1 = 256'hC3 << 100;
        a2 = pat;
        e1 = ref_rotr(a1, 256'd5);
        accept(a1, 256'd5, e1);
        collect(0, 8, 1'b0);
        a_in     = a2;
        shift_in = 256'd9;
        in_valid = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
            chk("hold_a_out", a_out, e1);
            chk("hold_in_ready", 256'(in_ready), 256'd0);
            chk("hold_out_valid", 256'(out_valid), 256'd1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("take_busy", 256'(busy), 256'd0);
        chk("take_in_ready", 256'(in_ready), 256'd1);
        @(posedge clk);
        exp_q.push_back(ref_rotr(a2, 256'd9));
        #1;
        in_valid = 1'b0;
        chk("second_accept_busy", 256'(busy), 256'd1);
        collect(0, 8, 1'b1);

        // Three stalled cycles in the middle of SHIFT.
        accept(pat, 256'hA5, ref_rotr(pat, 256'hA5));
        repeat (3) @(posedge clk);
        #1;
        enable = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("stall_busy", 256'(busy), 256'd1);
            chk("stall_out_valid", 256'(out_valid), 256'd0);
            chk("stall_in_ready", 256'(in_ready), 256'd0);
        end
        enable = 1'b1;
        collect(6, 11, 1'b1);

        // Asynchronous reset at stage 4 aborts the op.
        accept(~pat, 256'd77, ref_rotr(~pat, 256'd77));
        repeat (4) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("abort_a_out", a_out, 256'd0);
        chk("abort_out_valid", 256'(out_valid), 256'd0);
        chk("abort_busy", 256'(busy), 256'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        accept(pat, 256'd200, ref_rotr(pat, 256'd200));
        collect(0, 8, 1'b1);

        // Random operands and amounts, upper shift bits included.
        for (int n = 0; n < 1000; n++) begin
            a1 = rand256();
            sh = rand256();
            if ($urandom_range(0, 7) == 0) begin
                sh[7:0] = 8'd0;
            end
            el = (sh[7:0] == 8'd0) ? zlat : 8;
            accept(a1, sh, ref_rotr(a1, sh));
            collect(0, el, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
